// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA mode constants and timing helpers
package vga_timing_pkg;

    // 800x600 @ 60 Hz (40 MHz pixel clock)
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;
    localparam bit SVGA_HSYNC_POL = 1'b1;
    localparam bit SVGA_VSYNC_POL = 1'b1;

    // 640x480 @ 60 Hz (25.175 MHz pixel clock)
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam bit VGA_HSYNC_POL = 1'b0;
    localparam bit VGA_VSYNC_POL = 1'b0;

    localparam int DEFAULT_CW = 12;

    // True when a counter of cw bits can reach total-1
    function automatic bit timing_fits(input int total, input int cw);
        return longint'(total - 1) < (longint'(1) << cw);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis counter with region decode
module vga_axis_counter #(
    parameter int ACTIVE = 800,
    parameter int FP     = 40,
    parameter int SYNC   = 128,
    parameter int BP     = 88,
    parameter int CW     = 12
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_step,
    output logic [CW-1:0] o_count,
    output logic          o_wrap,
    output logic          o_in_active,
    output logic          o_in_sync
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACTIVE_END = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_BEG   = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign o_wrap = (count_q == LAST);

    // Next count: wrap to zero after the last tick of the axis
    always_comb begin
        count_d = o_wrap ? '0 : count_q + CW'(1);
    end

    // Counter advances only on steps; reset returns to the axis origin
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count_q <= '0;
        end else if (i_step) begin
            count_q <= count_d;
        end
    end

    assign o_count     = count_q;
    assign o_in_active = (count_q < ACTIVE_END);
    assign o_in_sync   = (count_q >= SYNC_BEG) && (count_q < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = SVGA_H_ACTIVE,
    parameter int H_FP      = SVGA_H_FP,
    parameter int H_SYNC    = SVGA_H_SYNC,
    parameter int H_BP      = SVGA_H_BP,
    parameter int V_ACTIVE  = SVGA_V_ACTIVE,
    parameter int V_FP      = SVGA_V_FP,
    parameter int V_SYNC    = SVGA_V_SYNC,
    parameter int V_BP      = SVGA_V_BP,
    parameter bit HSYNC_POL = SVGA_HSYNC_POL,
    parameter bit VSYNC_POL = SVGA_VSYNC_POL,
    parameter int CW        = DEFAULT_CW
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_pix_en,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_active,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_line_start,
    output logic          o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
        $fatal(1, "vga_timing_gen: every active/porch/sync parameter must be >= 1");
    end
    if (!timing_fits(H_TOTAL, CW) || !timing_fits(V_TOTAL, CW)) begin : g_bad_cw
        $fatal(1, "vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic          h_wrap;
    logic          v_wrap_unused;
    logic          h_in_active;
    logic          h_in_sync;
    logic          v_in_active;
    logic          v_in_sync;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CW     (CW)
    ) u_h_axis (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_step      (i_pix_en),
        .o_count     (h_count),
        .o_wrap      (h_wrap),
        .o_in_active (h_in_active),
        .o_in_sync   (h_in_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CW     (CW)
    ) u_v_axis (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_step      (i_pix_en && h_wrap),
        .o_count     (v_count),
        .o_wrap      (v_wrap_unused),
        .o_in_active (v_in_active),
        .o_in_sync   (v_in_sync)
    );

    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          active_q, active_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    // Decode of the pre-increment position, polarity applied here
    always_comb begin
        hsync_d       = h_in_sync ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = v_in_sync ? VSYNC_POL : ~VSYNC_POL;
        active_d      = h_in_active && v_in_active;
        x_d           = h_count;
        y_d           = v_count;
        line_start_d  = (h_count == '0);
        frame_start_d = (h_count == '0) && (v_count == '0);
    end

    // Output register: levels hold while gated, strobes drop so they stay one cycle wide
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            active_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (i_pix_en) begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_active      = active_q;
    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_line_start  = line_start_q;
    assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic en  = 1'b1;

    logic       hs, vs, act, ls, fs;
    logic [3:0] x, y;
    logic       hs_n, vs_n, act_n, ls_n, fs_n;
    logic [3:0] x_n, y_n;
    logic        hs_d, vs_d, act_d, ls_d, fs_d;
    logic [11:0] x_d, y_d;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(4)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_pix_en(en),
        .o_hsync(hs), .o_vsync(vs), .o_active(act), .o_x(x), .o_y(y),
        .o_line_start(ls), .o_frame_start(fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(4)
    ) dut_n (
        .i_clock(clk), .i_reset(rst), .i_pix_en(en),
        .o_hsync(hs_n), .o_vsync(vs_n), .o_active(act_n), .o_x(x_n), .o_y(y_n),
        .o_line_start(ls_n), .o_frame_start(fs_n)
    );

    vga_timing_gen dut_d (
        .i_clock(clk), .i_reset(rst), .i_pix_en(en),
        .o_hsync(hs_d), .o_vsync(vs_d), .o_active(act_d), .o_x(x_d), .o_y(y_d),
        .o_line_start(ls_d), .o_frame_start(fs_d)
    );

    typedef struct {
        logic       hs, vs, act, ls, fs;
        logic [3:0] x, y;
        int         id;
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   px = 0;
    int   py = 0;
    int   vec = 0;

    bit big_on = 1'b0;
    int rises, rise_x, hs_hi, ls_cnt, ls_period, fs_cnt, samp, last_ls;
    logic prev_hs_d;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Drive one cycle of inputs and push the outputs expected after the next edge
    task automatic tick(input bit r, input bit e);
        exp_t ex;
        @(negedge clk);
        rst = r;
        en  = e;
        if (r) begin
            ex.hs = 1'b0; ex.vs = 1'b0; ex.act = 1'b0; ex.ls = 1'b0; ex.fs = 1'b0;
            ex.x = 4'd0; ex.y = 4'd0;
            px = 0; py = 0;
        end else if (e) begin
            ex.x   = 4'(px);
            ex.y   = 4'(py);
            ex.act = (px < 4) && (py < 3);
            ex.hs  = (px == 5) || (px == 6);
            ex.vs  = (py == 4);
            ex.ls  = (px == 0);
            ex.fs  = (px == 0) && (py == 0);
            if (px == 7) begin
                px = 0;
                py = (py == 5) ? 0 : py + 1;
            end else begin
                px = px + 1;
            end
        end else begin
            ex = last_e;
            ex.ls = 1'b0;
            ex.fs = 1'b0;
        end
        ex.id = vec;
        vec++;
        sb.push_back(ex);
        last_e = ex;
    endtask

    // Monitor: pop and compare after each edge; also measure the default-mode DUT
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({hs, vs, act, ls, fs, x, y} !== {e.hs, e.vs, e.act, e.ls, e.fs, e.x, e.y}) begin
                    n_errors++;
                    $display("FAIL vec%0d pos: got hs=%b vs=%b act=%b ls=%b fs=%b x=%0d y=%0d expected hs=%b vs=%b act=%b ls=%b fs=%b x=%0d y=%0d",
                             e.id, hs, vs, act, ls, fs, x, y, e.hs, e.vs, e.act, e.ls, e.fs, e.x, e.y);
                end
                n_checks++;
                if ({hs_n, vs_n, act_n, ls_n, fs_n, x_n, y_n} !== {~e.hs, ~e.vs, e.act, e.ls, e.fs, e.x, e.y}) begin
                    n_errors++;
                    $display("FAIL vec%0d neg: got hs=%b vs=%b act=%b ls=%b fs=%b x=%0d y=%0d expected hs=%b vs=%b act=%b ls=%b fs=%b x=%0d y=%0d",
                             e.id, hs_n, vs_n, act_n, ls_n, fs_n, x_n, y_n, ~e.hs, ~e.vs, e.act, e.ls, e.fs, e.x, e.y);
                end
            end
            if (big_on) begin
                if (hs_d && !prev_hs_d) begin
                    rises++;
                    if (rises == 1) rise_x = int'(x_d);
                end
                if (hs_d) hs_hi++;
                if (ls_d) begin
                    ls_cnt++;
                    if (last_ls >= 0) ls_period = samp - last_ls;
                    last_ls = samp;
                end
                if (fs_d) fs_cnt++;
                prev_hs_d = hs_d;
                samp++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick(1'b1, 1'b1);
        repeat (48) tick(1'b0, 1'b1);
        while (!(px == 7 && py == 5)) tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) tick(1'b0, (i % 3) != 0);
        while (!(px == 3 && py == 2)) tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        repeat (10) tick(1'b0, 1'b1);

        @(negedge clk);
        rises = 0; rise_x = -1; hs_hi = 0; ls_cnt = 0; ls_period = 0;
        fs_cnt = 0; samp = 0; last_ls = -1; prev_hs_d = 1'b0;
        big_on = 1'b1;
        tick(1'b1, 1'b1);
        repeat (2200) tick(1'b0, 1'b1);
        @(posedge clk);
        #3;
        big_on = 1'b0;
        check("svga_hsync_rises", rises, 2);
        check("svga_hsync_start_x", rise_x, 840);
        check("svga_hsync_high_ticks", hs_hi, 256);
        check("svga_line_starts", ls_cnt, 3);
        check("svga_line_period", ls_period, 1056);
        check("svga_frame_starts", fs_cnt, 1);
        check("svga_final_x", int'(x_d), 87);
        check("svga_final_y", int'(y_d), 2);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
